// File: rtl/team_06_effect_engine.sv
// team_06_effect_engine: sequenced audio-effect processor (bypass, tremolo,
// echo, soft clip, feedback reverb) with an external SRAM delay line.
module team_06_effect_engine #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned TREM_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  audio_in,
    input  logic              sample_valid,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [2:0]        fb_shift,
    output logic [WIDTH-1:0]  audio_out,
    output logic              out_valid,
    output logic              busy,
    output logic              drop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned SW    = WIDTH + 1;
    localparam int unsigned PW    = WIDTH + 9;
    localparam int unsigned DIV_W = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;

    localparam logic [2:0] SEL_TREM = 3'd1;
    localparam logic [2:0] SEL_ECHO = 3'd2;
    localparam logic [2:0] SEL_CLIP = 3'd3;
    localparam logic [2:0] SEL_REVB = 3'd4;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SW-1:0]    CLIP_T  = SW'(2 ** (WIDTH - 2));
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TREM_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CALC,
        S_WR,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] dl_q, dl_d;
    logic [2:0]        fbs_q, fbs_d;
    logic [7:0]        gain_q, gain_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [7:0]        t_q, t_d;
    logic              t_up_q, t_up_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              prev_delay_q, prev_delay_d;
    logic [WIDTH-1:0]  audio_out_q, audio_out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] dl_eff_c;
    logic              sel_delay_c;
    logic              mode_delay_c;

    logic [SW-1:0]        x_ext_c, d_ext_c;
    logic [3:0]           revb_shamt_c;
    logic [SW-1:0]        echo_sum_c, revb_sum_c;
    logic signed [PW-1:0] trem_prod_c;
    logic [WIDTH-1:0]     trem_y_c;
    logic [SW-1:0]        clip_abs_c, clip_mag_c, clip_sgn_c;
    logic [WIDTH-1:0]     clip_y_c;
    logic [WIDTH-1:0]     y_c;
    logic                 unused_c;

    // Clamp a WIDTH+1 bit signed sum back into the WIDTH-bit range.
    function automatic logic [WIDTH-1:0] sat_f(input logic [SW-1:0] s);
        if (s[SW-1] != s[SW-2]) begin
            return s[SW-1] ? SAT_MIN : SAT_MAX;
        end
        return s[WIDTH-1:0];
    endfunction

    // Input decode: effective delay and whether the offered sample needs the delay line.
    always_comb begin
        dl_eff_c     = (delay_len == '0) ? ADDR_W'(1) : delay_len;
        sel_delay_c  = (sel == SEL_ECHO) || (sel == SEL_REVB);
        mode_delay_c = (mode_q == SEL_ECHO) || (mode_q == SEL_REVB);
    end

    // Effect arithmetic on the latched sample and delayed term.
    always_comb begin
        x_ext_c      = {x_q[WIDTH-1], x_q};
        d_ext_c      = {d_q[WIDTH-1], d_q};
        revb_shamt_c = {1'b0, fbs_q} + 4'd1;
        echo_sum_c   = x_ext_c + SW'($signed(d_ext_c) >>> 1);
        revb_sum_c   = x_ext_c + SW'($signed(d_ext_c) >>> revb_shamt_c);

        trem_prod_c  = $signed({{9{x_q[WIDTH-1]}}, x_q}) * $signed({{(WIDTH+1){1'b0}}, gain_q});
        trem_y_c     = trem_prod_c[WIDTH+7:8];

        // Magnitude in WIDTH+1 bits so the most negative input does not overflow.
        clip_abs_c   = x_q[WIDTH-1] ? (~x_ext_c + SW'(1)) : x_ext_c;
        clip_mag_c   = clip_abs_c;
        clip_sgn_c   = x_ext_c;
        clip_y_c     = x_q;
        if (clip_abs_c > CLIP_T) begin
            clip_mag_c = CLIP_T + ((clip_abs_c - CLIP_T) >> 1);
            clip_sgn_c = x_q[WIDTH-1] ? (~clip_mag_c + SW'(1)) : clip_mag_c;
            clip_y_c   = clip_sgn_c[WIDTH-1:0];
        end

        case (mode_q)
            SEL_TREM: y_c = trem_y_c;
            SEL_ECHO: y_c = sat_f(echo_sum_c);
            SEL_CLIP: y_c = clip_y_c;
            SEL_REVB: y_c = sat_f(revb_sum_c);
            default:  y_c = x_q;
        endcase
    end

    assign unused_c = ^{trem_prod_c[PW-1], trem_prod_c[7:0], clip_sgn_c[SW-1]};

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        mode_d       = mode_q;
        dl_d         = dl_q;
        fbs_d        = fbs_q;
        gain_d       = gain_q;
        d_d          = d_q;
        y_d          = y_q;
        wp_d         = wp_q;
        fill_d       = fill_q;
        t_d          = t_q;
        t_up_d       = t_up_q;
        div_d        = div_q;
        prev_delay_d = prev_delay_q;
        audio_out_d  = audio_out_q;
        out_valid_d  = 1'b0;
        drop_d       = sample_valid && (state_q != S_IDLE);
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    x_d    = audio_in;
                    mode_d = sel;
                    dl_d   = dl_eff_c;
                    fbs_d  = fb_shift;
                    gain_d = 8'd128 + {1'b0, t_q[7:1]};
                    // Triangle LFO advances once every TREM_DIV accepted samples.
                    if (div_q == DIV_MAX) begin
                        div_d = '0;
                        if (t_up_q) begin
                            if (t_q == 8'hFF) begin
                                t_d    = 8'hFE;
                                t_up_d = 1'b0;
                            end else begin
                                t_d = t_q + 8'd1;
                            end
                        end else begin
                            if (t_q == 8'h00) begin
                                t_d    = 8'h01;
                                t_up_d = 1'b1;
                            end else begin
                                t_d = t_q - 8'd1;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                    if (sel_delay_c) begin
                        prev_delay_d = 1'b1;
                        if (!prev_delay_q) begin
                            fill_d = '0;
                        end
                        mem_addr_d = wp_q - dl_eff_c;
                        mem_read_d = 1'b1;
                        state_d    = S_RD;
                    end else begin
                        prev_delay_d = 1'b0;
                        state_d      = S_CALC;
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    // Unprimed delay line reads as silence.
                    d_d        = (fill_q < dl_q) ? '0 : mem_rdata;
                    mem_read_d = 1'b0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                y_d = y_c;
                if (mode_delay_c) begin
                    mem_addr_d  = wp_q;
                    mem_wdata_d = (mode_q == SEL_ECHO) ? x_q : y_c;
                    mem_write_d = 1'b1;
                    state_d     = S_WR;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    mem_write_d = 1'b0;
                    wp_d        = wp_q + ADDR_W'(1);
                    if (fill_q < dl_q) begin
                        fill_d = fill_q + ADDR_W'(1);
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                audio_out_d = y_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            mode_q       <= '0;
            dl_q         <= ADDR_W'(1);
            fbs_q        <= '0;
            gain_q       <= 8'd128;
            d_q          <= '0;
            y_q          <= '0;
            wp_q         <= '0;
            fill_q       <= '0;
            t_q          <= '0;
            t_up_q       <= 1'b1;
            div_q        <= '0;
            prev_delay_q <= 1'b0;
            audio_out_q  <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            mode_q       <= mode_d;
            dl_q         <= dl_d;
            fbs_q        <= fbs_d;
            gain_q       <= gain_d;
            d_q          <= d_d;
            y_q          <= y_d;
            wp_q         <= wp_d;
            fill_q       <= fill_d;
            t_q          <= t_d;
            t_up_q       <= t_up_d;
            div_q        <= div_d;
            prev_delay_q <= prev_delay_d;
            audio_out_q  <= audio_out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign audio_out = audio_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign drop      = drop_q;
    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;

endmodule
